// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the word-serial wide adder: FSM encoding and slice width.
package wide_add_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_seq_mix16bitaddr.sv
// 16-bit adder slice: ripple low byte, carry-select high byte.
module mix16bitaddr (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  always_comb begin
    lo  = {1'b0, A[7:0]} + {1'b0, B[7:0]} + {8'b0, Cin};
    // Both high-byte results are precomputed; the low carry only picks one.
    hi0 = {1'b0, A[15:8]} + {1'b0, B[15:8]};
    hi1 = {1'b0, A[15:8]} + {1'b0, B[15:8]} + 9'd1;
    Sum  = lo[8] ? {hi1[7:0], lo[7:0]} : {hi0[7:0], lo[7:0]};
    Cout = lo[8] ? hi1[8] : hi0[8];
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-word add/subtract that reuses one 16-bit slice, one word per cycle, LSW first.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter  int unsigned WORDS = 4,
  localparam int unsigned W     = WORD_W * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e            state_q;
  logic [W-1:0]      opa_q;
  logic [W-1:0]      opb_q;
  logic              carry_q;
  logic              sub_q;
  logic [IdxW-1:0]   idx_q;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] s_word;
  logic              c_word;
  logic              ovf_word;

  assign a_word   = opa_q[idx_q*WORD_W +: WORD_W];
  assign b_word   = opb_q[idx_q*WORD_W +: WORD_W];
  assign ovf_word = (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                    (s_word[WORD_W-1] != a_word[WORD_W-1]);

  mix16bitaddr u_slice (
    .A   (a_word),
    .B   (b_word),
    .Cin (carry_q),
    .Sum (s_word),
    .Cout(c_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            opa_q    <= a;
            // Subtract as A + ~B + 1; the +1 enters as the initial carry.
            opb_q    <= sub ? ~b : b;
            carry_q  <= sub;
            sub_q    <= sub;
            idx_q    <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          sum[idx_q*WORD_W +: WORD_W] <= s_word;
          carry_q <= c_word;
          if (idx_q == LastIdx) begin
            cout      <= c_word;
            overflow  <= ovf_word;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with WORDS=4 (64-bit operands).
module tb_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge, idle again.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic [W-1:0] es, input logic ec,
                        input logic eo);
    int cyc;
    check({tag, " in_ready"}, W'(in_ready), W'(1));
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, " latency"}, W'(cyc), W'(WORDS));
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, W'(cout), W'(ec));
    check({tag, " overflow"}, W'(overflow), W'(eo));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    int cyc;
    int hits[$];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset sum", sum, '0);
    check("reset cout", W'(cout), W'(0));
    check("reset overflow", W'(overflow), W'(0));

    run_op("all_ones_plus_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("5_minus_7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("7_minus_5", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("max_pos_plus_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("min_neg_minus_1", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("word_carry_chain", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
           64'h0001_0000_0001_0000, 1'b0, 1'b0);

    // Backpressure: new requests during RUN/DONE must be ignored and the result held.
    a = 64'd7; b = 64'd5; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 64'hDEAD_BEEF_0000_1111; b = 64'h1234_5678_9ABC_DEF0; sub = 1'b0;
    check("bp run in_ready", W'(in_ready), W'(0));
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("bp latency", W'(cyc), W'(WORDS));
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", W'(out_valid), W'(1));
      check("bp in_ready", W'(in_ready), W'(0));
      check("bp sum", sum, 64'd2);
      check("bp cout", W'(cout), W'(1));
      check("bp overflow", W'(overflow), W'(0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release", W'(in_ready), W'(1));

    // Reset while RUN is on word 2.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun rst in_ready", W'(in_ready), W'(1));
    check("midrun rst out_valid", W'(out_valid), W'(0));
    check("midrun rst sum", sum, '0);
    repeat (WORDS + 2) @(negedge clk);
    check("midrun no output", W'(out_valid), W'(0));
    run_op("after_rst", 64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0);

    // Back-to-back: in_valid and out_ready held high; acceptances every WORDS+2 cycles.
    a = 64'd1; b = 64'd2; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) hits.push_back(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b accept count", W'(hits.size()), W'(4));
    for (int i = 1; i < hits.size(); i++) begin
      check("b2b interval", W'(hits[i] - hits[i-1]), W'(WORDS + 2));
    end
    repeat (WORDS + 3) @(negedge clk);
    out_ready = 1'b0;
    check("b2b drained", W'(in_ready), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
